// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG health-test and byte-packing block.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STARTUP = 2'd1,
    RUN     = 2'd2,
    FAIL    = 2'd3
  } trng_state_e;

  localparam logic [1:0] FAIL_NONE = 2'b00;
  localparam logic [1:0] FAIL_RCT  = 2'b01;
  localparam logic [1:0] FAIL_APT  = 2'b10;
  localparam logic [1:0] FAIL_BOTH = 2'b11;

  localparam int DEF_STARTUP_BITS = 1024;
  localparam int DEF_RCT_CUTOFF   = 32;
  localparam int DEF_APT_WINDOW   = 512;
  localparam int DEF_APT_CUTOFF   = 410;

  // Map the two per-bit test verdicts onto the reported failure cause.
  function automatic logic [1:0] encode_fail(input logic rct, input logic apt);
    logic [1:0] code;
    case ({apt, rct})
      2'b01:   code = FAIL_RCT;
      2'b10:   code = FAIL_APT;
      2'b11:   code = FAIL_BOTH;
      default: code = FAIL_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/trng_byte_packer.sv
// Packs accepted random bits LSB-first into bytes and presents them on a
// valid/ready port; a completed byte that cannot be stored sets a sticky flag.
module trng_byte_packer
  import trng_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       bit_in,
  input  logic       flush,
  input  logic       clear_ovf,
  input  logic       byte_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       overflow
);

  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] byte_r;
  logic       valid_r;
  logic       ovf_r;

  logic [7:0] full_s;
  logic       complete_s;
  logic       accept_s;
  logic       load_s;

  // Assemble the byte including the current bit and decide whether it can be stored.
  always_comb begin
    full_s            = shift_r;
    full_s[bit_cnt_r] = bit_in;
    complete_s        = shift_en && (bit_cnt_r == 3'd7);
    accept_s          = valid_r && byte_ready;
    load_s            = complete_s && (!valid_r || byte_ready);
  end

  // Partial-byte shift register and bit position; discarded whenever packing is inactive.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
    end else if (flush) begin
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
    end else if (complete_s) begin
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
    end else if (shift_en) begin
      shift_r   <= full_s;
      bit_cnt_r <= bit_cnt_r + 3'd1;
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Output holding register: a new byte may replace one that is accepted this cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      byte_r  <= 8'h00;
      valid_r <= 1'b0;
    end else if (load_s) begin
      byte_r  <= full_s;
      valid_r <= 1'b1;
    end else if (accept_s) begin
      byte_r  <= byte_r;
      valid_r <= 1'b0;
    end else begin
      byte_r  <= byte_r;
      valid_r <= valid_r;
    end
  end

  // Sticky drop flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ovf_r <= 1'b0;
    end else if (complete_s && !load_s) begin
      ovf_r <= 1'b1;
    end else if (clear_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign byte_out   = byte_r;
  assign byte_valid = valid_r;
  assign overflow   = ovf_r;

endmodule

// File: rtl/trng_health_packer.sv
// Continuous repetition-count and adaptive-proportion health tests on the
// random bit stream, with startup qualification and a sticky failure state.
module trng_health_packer
  import trng_pkg::*;
#(
  parameter int STARTUP_BITS = DEF_STARTUP_BITS,
  parameter int RCT_CUTOFF   = DEF_RCT_CUTOFF,
  parameter int APT_WINDOW   = DEF_APT_WINDOW,
  parameter int APT_CUTOFF   = DEF_APT_CUTOFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       clear_fail,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       health_fail,
  output logic [1:0] fail_code,
  output logic       overflow,
  output logic [1:0] state_o
);

  localparam int RW  = $clog2(RCT_CUTOFF + 1);
  localparam int AMW = $clog2(APT_CUTOFF + 1);
  localparam int AWW = $clog2(APT_WINDOW + 1);
  localparam int SW  = $clog2(STARTUP_BITS + 1);

  trng_state_e    state_r, state_n;
  logic [1:0]     fail_code_r, fail_code_n;
  logic           health_fail_r;

  logic [RW-1:0]  run_cnt_r, run_cnt_c;
  logic           prev_bit_r;
  logic           ref_bit_r, ref_bit_c;
  logic [AMW-1:0] match_cnt_r, match_cnt_c;
  logic [AWW-1:0] win_cnt_r, win_cnt_c;
  logic [SW-1:0]  startup_cnt_r;

  logic active_s, testing_s, new_win_s;
  logic rct_fail_s, apt_fail_s, any_fail_s, startup_done_s, keep_s, shift_en_s;

  // Evaluate both health tests on the incoming bit and derive the next counter values.
  always_comb begin
    active_s  = (state_r == STARTUP) || (state_r == RUN);
    testing_s = active_s && bit_valid;
    run_cnt_c = RW'(1);
    if ((run_cnt_r != '0) && (bit_in == prev_bit_r)) begin
      run_cnt_c = run_cnt_r + RW'(1);
    end else begin
      run_cnt_c = RW'(1);
    end
    new_win_s   = (win_cnt_r == '0) || (win_cnt_r == AWW'(APT_WINDOW));
    ref_bit_c   = ref_bit_r;
    match_cnt_c = match_cnt_r;
    win_cnt_c   = win_cnt_r;
    if (new_win_s) begin
      ref_bit_c   = bit_in;
      match_cnt_c = AMW'(1);
      win_cnt_c   = AWW'(1);
    end else if (bit_in == ref_bit_r) begin
      match_cnt_c = match_cnt_r + AMW'(1);
      win_cnt_c   = win_cnt_r + AWW'(1);
    end else begin
      win_cnt_c   = win_cnt_r + AWW'(1);
    end
    rct_fail_s     = testing_s && (run_cnt_c == RW'(RCT_CUTOFF));
    apt_fail_s     = testing_s && (match_cnt_c == AMW'(APT_CUTOFF));
    any_fail_s     = rct_fail_s || apt_fail_s;
    startup_done_s = testing_s && !any_fail_s && (startup_cnt_r == SW'(STARTUP_BITS - 1));
  end

  // Next-state and failure-cause logic; a failure outranks enable dropping.
  always_comb begin
    state_n     = state_r;
    fail_code_n = fail_code_r;
    case (state_r)
      IDLE: begin
        if (enable) state_n = STARTUP;
        else        state_n = IDLE;
      end
      STARTUP: begin
        if (any_fail_s) begin
          state_n     = FAIL;
          fail_code_n = encode_fail(rct_fail_s, apt_fail_s);
        end else if (!enable)      state_n = IDLE;
        else if (startup_done_s)   state_n = RUN;
        else                       state_n = STARTUP;
      end
      RUN: begin
        if (any_fail_s) begin
          state_n     = FAIL;
          fail_code_n = encode_fail(rct_fail_s, apt_fail_s);
        end else if (!enable) state_n = IDLE;
        else                  state_n = RUN;
      end
      FAIL: begin
        if (clear_fail) begin
          state_n     = IDLE;
          fail_code_n = FAIL_NONE;
        end else begin
          state_n     = FAIL;
        end
      end
      default: begin
        state_n     = IDLE;
        fail_code_n = FAIL_NONE;
      end
    endcase
  end

  // State register and the registered status outputs derived from the next state.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r       <= IDLE;
      fail_code_r   <= FAIL_NONE;
      health_fail_r <= 1'b0;
    end else begin
      state_r       <= state_n;
      fail_code_r   <= fail_code_n;
      health_fail_r <= (state_n == FAIL);
    end
  end

  assign keep_s = active_s && (state_n != IDLE);

  // Test counters: cleared outside STARTUP/RUN and when leaving to IDLE.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      run_cnt_r     <= '0;
      prev_bit_r    <= 1'b0;
      ref_bit_r     <= 1'b0;
      match_cnt_r   <= '0;
      win_cnt_r     <= '0;
      startup_cnt_r <= '0;
    end else if (!keep_s) begin
      run_cnt_r     <= '0;
      prev_bit_r    <= 1'b0;
      ref_bit_r     <= 1'b0;
      match_cnt_r   <= '0;
      win_cnt_r     <= '0;
      startup_cnt_r <= '0;
    end else if (testing_s) begin
      run_cnt_r     <= run_cnt_c;
      prev_bit_r    <= bit_in;
      ref_bit_r     <= ref_bit_c;
      match_cnt_r   <= match_cnt_c;
      win_cnt_r     <= win_cnt_c;
      startup_cnt_r <= (state_r == STARTUP) ? (startup_cnt_r + SW'(1)) : startup_cnt_r;
    end else begin
      run_cnt_r     <= run_cnt_r;
      prev_bit_r    <= prev_bit_r;
      ref_bit_r     <= ref_bit_r;
      match_cnt_r   <= match_cnt_r;
      win_cnt_r     <= win_cnt_r;
      startup_cnt_r <= startup_cnt_r;
    end
  end

  // Only bits that pass in RUN with enable still high are packed.
  assign shift_en_s = (state_r == RUN) && bit_valid && enable && !any_fail_s;

  trng_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (shift_en_s),
    .bit_in     (bit_in),
    .flush      (state_r != RUN),
    .clear_ovf  (clear_fail),
    .byte_ready (byte_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .overflow   (overflow)
  );

  assign state_o     = state_r;
  assign fail_code   = fail_code_r;
  assign health_fail = health_fail_r;

endmodule

// File: doc/trng_health_packer.md
# trng_health_packer

Downstream consumer of the post-processed random bit stream (the XOR of the ring-oscillator path and the LFSR path). It runs continuous SP 800-90B-style health tests on every incoming bit: a repetition-count test (RCT) and an adaptive-proportion test (APT). Bits that pass are packed LSB-first into bytes and presented on a valid/ready output port. A startup qualification phase must pass before any byte is released, and a sticky FAIL state latches on any test failure.

## Interface
Parameters:
- STARTUP_BITS, 1024: valid bits that must pass the health tests before output is enabled.
- RCT_CUTOFF, 32: run length of identical bits that triggers an RCT failure.
- APT_WINDOW, 512: APT window length in bits.
- APT_CUTOFF, 410: count of matches to the window reference bit that triggers an APT failure.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- enable  in  1  level; 1 = run, 0 = return to IDLE.
- bit_in  in  1  random bit.
- bit_valid  in  1  bit_in is consumed this cycle; at most one bit per cycle.
- clear_fail  in  1  pulse; leaves FAIL.
- byte_out  out  8  packed byte; bit 0 is the oldest bit.
- byte_valid  out  1  byte_out is held stable until accepted.
- byte_ready  in  1  sink accepts on byte_valid & byte_ready.
- health_fail  out  1  high while in FAIL.
- fail_code  out  2  00 none, 01 RCT, 10 APT, 11 both on the same bit.
- overflow  out  1  sticky; a completed byte was dropped. Cleared by clear_fail or reset.
- state_o  out  2  current FSM state.

## Operation
FSM states: IDLE=0, STARTUP=1, RUN=2, FAIL=3.
- IDLE -> STARTUP when enable=1. On entry, all test counters are cleared and the partial byte is discarded.
- STARTUP -> RUN on the cycle the STARTUP_BITS-th valid bit passes.
- STARTUP/RUN -> FAIL on any test failure; fail_code records the cause.
- STARTUP/RUN -> IDLE when enable=0; all counters are cleared.
- FAIL -> IDLE on clear_fail; fail_code returns to 00. FAIL ignores enable.
- clear_fail outside FAIL clears overflow only.

RCT:
- The first valid bit after entering STARTUP sets run_cnt=1.
- A subsequent bit equal to the previous bit increments run_cnt; otherwise run_cnt=1.
- Failure when run_cnt reaches RCT_CUTOFF.
- run_cnt width is $clog2(RCT_CUTOFF+1).

APT:
- The first bit of each window is latched as the reference, with match_cnt=1 and win_cnt=1.
- Each subsequent bit increments win_cnt, and increments match_cnt if it equals the reference.
- Failure when match_cnt reaches APT_CUTOFF.
- When win_cnt reaches APT_WINDOW, the next valid bit starts a new window.

Packing:
- Active only in RUN. STARTUP bits are tested but never packed.
- Bits shift into an 8-bit register at position bit_cnt (0..7).
- On the 8th bit, the byte goes to the output register if the register is empty or is being accepted in the same cycle. Otherwise the byte is dropped and overflow is set.
- A pending output byte survives transitions to IDLE and FAIL until it is accepted.

Boundary rules:
- Failure detected on the 8th bit: the byte is discarded.
- Accept and a new byte completing in the same cycle: the new byte loads, byte_valid stays 1, and overflow is not set.
- enable falls in the same cycle as a failure: FAIL wins.
- Reset mid-operation: immediate return to IDLE; the pending byte is lost.

## Timing
- Reset values: byte_out=0, byte_valid=0, health_fail=0, fail_code=0, overflow=0, state_o=0.
- All outputs are registered.
- Failure: state_o=3 and health_fail=1 in the cycle after the offending bit_valid.
- Byte latency: byte_valid rises in the cycle after the 8th bit is accepted.
- byte_valid falls in the cycle after an accept, unless a new byte loads in that same cycle.
- Back-to-back: bit_valid=1 every cycle with byte_ready=1 gives one byte every 8 cycles with no stall.
- STARTUP->RUN: the bit that completes STARTUP_BITS is not packed. Packing begins with the next valid bit.

## Structure
- Package trng_pkg holds:
  - state enum trng_state_e (IDLE, STARTUP, RUN, FAIL);
  - fail code constants FAIL_NONE, FAIL_RCT, FAIL_APT, FAIL_BOTH;
  - default cutoff localparams.
- Sub-module trng_byte_packer contains the shift register, bit counter, output register, valid/ready logic and overflow flag.
- The top level contains the FSM and the RCT/APT counters.
- Target size is about 250 lines.

## Test plan
Bench parameters: STARTUP_BITS=16, RCT_CUTOFF=8, APT_WINDOW=32, APT_CUTOFF=24.
- Alternating 1010... with enable=1 and byte_ready=1 -> RUN after 16 bits; bytes 0x55 every 8 cycles; health_fail stays 0.
- Eight consecutive 1s in RUN -> FAIL the next cycle, fail_code=01, the partial byte is discarded; clear_fail -> IDLE.
- Pattern 1110 repeated (24 ones in 32 bits, no run of 8) -> APT failure, fail_code=10.
- byte_ready=0 for 16 bits in RUN -> first byte held stable, second byte dropped, overflow=1; the held byte is still accepted afterwards.
- enable dropped mid-byte, then raised again -> STARTUP again; 16 fresh bits are required before the next byte appears.
- Assert rst_n in RUN with byte_valid=1 -> every output returns to 0 immediately.
